regfile_wb_arbiter: RTL and testbench

Write-back arbiter and scoreboard for the 8×19-bit register file. It shares the register file's single write port between two producers, the ALU and the load unit, using round-robin arbitration and a registered write stage. It also tracks which destination registers have writes outstanding, so that decode can stall on read-after-write hazards. The block sits between the execute/memory stages and the register file's `rd`/`write_data`/`write_enable` inputs.

---
 rtl/cpu19_pkg.sv | 20 ++
 rtl/regfile_wb_arbiter_if.sv | 49 ++++
 rtl/regfile_wb_arbiter_rr_arb2.sv | 25 ++
 rtl/regfile_wb_arbiter.sv | 82 ++++++++
 tb/tb_regfile_wb_arbiter.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/cpu19_pkg.sv
// Shared types and sizes for the 19-bit core's register file path.
// Provides the register index/data typedefs and a one-hot decode helper.
package cpu19_pkg;

   localparam int DATA_W = 19;
   localparam int ADDR_W = 3;
   localparam int NREG   = 8;

   typedef logic [ADDR_W-1:0] reg_idx_t;
   typedef logic [DATA_W-1:0] reg_data_t;
   typedef logic [NREG-1:0]   reg_mask_t;

   function automatic reg_mask_t onehot(reg_idx_t idx);
      reg_mask_t m;
      m = '0;
      m[idx] = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back request, register-file write and scoreboard bundle.
// master = producers/decode side, slave = arbiter side.
interface regfile_wb_arbiter_if;
   import cpu19_pkg::*;

   logic      alu_valid;
   logic      alu_ready;
   reg_idx_t  alu_rd;
   reg_data_t alu_data;

   logic      mem_valid;
   logic      mem_ready;
   reg_idx_t  mem_rd;
   reg_data_t mem_data;

   logic      rf_we;
   reg_idx_t  rf_rd;
   reg_data_t rf_wdata;

   logic      issue_valid;
   logic      issue_ready;
   reg_idx_t  issue_rd;
   reg_idx_t  chk_rs1;
   reg_idx_t  chk_rs2;
   logic      hazard_rs1;
   logic      hazard_rs2;
   reg_mask_t busy;

   modport master (
      output alu_valid, alu_rd, alu_data,
      input  alu_ready,
      output mem_valid, mem_rd, mem_data,
      input  mem_ready,
      input  rf_we, rf_rd, rf_wdata,
      output issue_valid, issue_rd, chk_rs1, chk_rs2,
      input  issue_ready, hazard_rs1, hazard_rs2, busy
   );

   modport slave (
      input  alu_valid, alu_rd, alu_data,
      output alu_ready,
      input  mem_valid, mem_rd, mem_data,
      output mem_ready,
      output rf_we, rf_rd, rf_wdata,
      input  issue_valid, issue_rd, chk_rs1, chk_rs2,
      output issue_ready, hazard_rs1, hazard_rs2, busy
   );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; req[0]=ALU, req[1]=load unit.
// The pointer resets to "MEM last" so the ALU wins the first tie.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   logic r_last_mem;

   always_comb begin
      gnt    = 2'b00;
      gnt[0] = req[0] & (~req[1] | r_last_mem);
      gnt[1] = req[1] & (~req[0] | ~r_last_mem);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_last_mem <= 1'b1;
      else if (|gnt)
         r_last_mem <= gnt[1];
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter, registered write stage and pending-write scoreboard.
// Scoreboard present only when REGFILE_WB_SCOREBOARD_EN is defined.
module regfile_wb_arbiter
   import cpu19_pkg::*;
(
   input logic                 clk,
   input logic                 rst_n,
   regfile_wb_arbiter_if.slave bus
);

   logic [1:0] w_gnt;
   logic       r_rf_we;
   reg_idx_t   r_rf_rd;
   reg_data_t  r_rf_wdata;

   rr_arb2 u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req   ({bus.mem_valid, bus.alu_valid}),
      .gnt   (w_gnt)
   );

   assign bus.alu_ready = w_gnt[0];
   assign bus.mem_ready = w_gnt[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rf_we    <= 1'b0;
         r_rf_rd    <= '0;
         r_rf_wdata <= '0;
      end else begin
         r_rf_we <= |w_gnt;
         if (w_gnt[0]) begin
            r_rf_rd    <= bus.alu_rd;
            r_rf_wdata <= bus.alu_data;
         end else if (w_gnt[1]) begin
            r_rf_rd    <= bus.mem_rd;
            r_rf_wdata <= bus.mem_data;
         end
      end
   end

   assign bus.rf_we    = r_rf_we;
   assign bus.rf_rd    = r_rf_rd;
   assign bus.rf_wdata = r_rf_wdata;

`ifdef REGFILE_WB_SCOREBOARD_EN
   reg_mask_t r_busy;
   reg_mask_t w_set;
   reg_mask_t w_clr;
   logic      w_issue_ok;

   assign w_issue_ok = ~r_busy[bus.issue_rd];
   assign w_set = (bus.issue_valid && w_issue_ok) ?
                  onehot(bus.issue_rd) : '0;
   assign w_clr = r_rf_we ? onehot(r_rf_rd) : '0;

   // A same-edge issue re-arms the bit the retiring write clears
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_busy <= '0;
      else
         r_busy <= (r_busy & ~w_clr) | w_set;
   end

   assign bus.busy        = r_busy;
   assign bus.issue_ready = w_issue_ok;
   assign bus.hazard_rs1  = r_busy[bus.chk_rs1];
   assign bus.hazard_rs2  = r_busy[bus.chk_rs2];
`else
   logic w_unused;

   assign w_unused = ^{bus.issue_valid, bus.issue_rd,
                       bus.chk_rs1, bus.chk_rs2};

   assign bus.busy        = '0;
   assign bus.issue_ready = 1'b1;
   assign bus.hazard_rs1  = 1'b0;
   assign bus.hazard_rs2  = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a write-back scoreboard queue.
// Scoreboard checks compile in when REGFILE_WB_SCOREBOARD_EN is defined.
module tb_regfile_wb_arbiter;
   import cpu19_pkg::*;

   logic clk;
   logic rst_n;
   int   tests;
   int   fails;
   logic m_last_mem;

   logic [ADDR_W+DATA_W-1:0] q[$];

   regfile_wb_arbiter_if bus ();

   regfile_wb_arbiter dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected winner from the bench's own pointer model
   task automatic arb_step();
      logic ea;
      logic em;
      #1;
      ea = bus.alu_valid && (!bus.mem_valid || m_last_mem);
      em = bus.mem_valid && (!bus.alu_valid || !m_last_mem);
      chk("alu_ready", bus.alu_ready, ea);
      chk("mem_ready", bus.mem_ready, em);
      if (ea) q.push_back({bus.alu_rd, bus.alu_data});
      else if (em) q.push_back({bus.mem_rd, bus.mem_data});
      if (ea || em) m_last_mem = em;
      tick();
   endtask

   always @(negedge clk) begin
      if (rst_n && bus.rf_we) begin
         chk("wb_expected", q.size() != 0, 1);
         if (q.size() != 0)
            chk("wb_rd_data", {bus.rf_rd, bus.rf_wdata}, q.pop_front());
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      q.delete();
      m_last_mem = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      tests = 0;
      fails = 0;
      m_last_mem = 1'b1;
      rst_n = 1'b0;
      bus.alu_valid = 0; bus.alu_rd = '0; bus.alu_data = '0;
      bus.mem_valid = 0; bus.mem_rd = '0; bus.mem_data = '0;
      bus.issue_valid = 0; bus.issue_rd = '0;
      bus.chk_rs1 = '0; bus.chk_rs2 = '0;
      #12;
      chk("rst_rf_we", bus.rf_we, 0);
      chk("rst_rf_rd", bus.rf_rd, 0);
      chk("rst_rf_wdata", bus.rf_wdata, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_alu_ready", bus.alu_ready, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // ALU only
      bus.alu_valid = 1; bus.alu_rd = 3; bus.alu_data = 19'h1ABCD;
      arb_step();
      bus.alu_valid = 0;
      chk("s1_we", bus.rf_we, 1);
      chk("s1_rd", bus.rf_rd, 3);
      chk("s1_wdata", bus.rf_wdata, 32'h1ABCD);
      tick();
      chk("s1_we_drop", bus.rf_we, 0);
      chk("s1_rd_hold", bus.rf_rd, 3);

      // Tie for four cycles from a fresh pointer
      do_reset();
      bus.alu_valid = 1; bus.alu_rd = 1; bus.alu_data = 19'h11111;
      bus.mem_valid = 1; bus.mem_rd = 2; bus.mem_data = 19'h22222;
      for (int i = 0; i < 4; i++) begin
         arb_step();
         chk("s2_we", bus.rf_we, 1);
         chk("s2_rd", bus.rf_rd, (i % 2 == 0) ? 1 : 2);
      end
      bus.alu_valid = 0; bus.mem_valid = 0;
      tick();
      chk("s2_we_drop", bus.rf_we, 0);

`ifdef REGFILE_WB_SCOREBOARD_EN
      bus.issue_valid = 1; bus.issue_rd = 5;
      #1;
      chk("s3_issue_ready", bus.issue_ready, 1);
      tick();
      bus.issue_valid = 0; bus.chk_rs1 = 5; bus.chk_rs2 = 1;
      #1;
      chk("s3_hazard1", bus.hazard_rs1, 1);
      chk("s3_hazard2", bus.hazard_rs2, 0);
      chk("s3_busy", bus.busy, 32'h20);
      bus.issue_valid = 1; bus.issue_rd = 5;
      #1;
      chk("s3_waw_block", bus.issue_ready, 0);
      tick();
      bus.issue_valid = 0;
      chk("s3_busy_hold", bus.busy, 32'h20);
      bus.mem_valid = 1; bus.mem_rd = 5; bus.mem_data = 19'h7F00F;
      arb_step();
      bus.mem_valid = 0;
      chk("s3_commit_we", bus.rf_we, 1);
      chk("s3_hazard_held", bus.hazard_rs1, 1);
      tick();
      chk("s3_hazard_clr", bus.hazard_rs1, 0);
      chk("s3_busy_clr", bus.busy, 0);

      bus.alu_valid = 1; bus.alu_rd = 4; bus.alu_data = 19'h00444;
      arb_step();
      bus.alu_valid = 0;
      bus.issue_valid = 1; bus.issue_rd = 4;
      #1;
      chk("s4_issue_ready", bus.issue_ready, 1);
      tick();
      bus.issue_valid = 0;
      chk("s4_set_wins", bus.busy, 32'h10);

      for (int i = 0; i < 8; i++) begin
         if (i != 4) begin
            bus.issue_valid = 1; bus.issue_rd = reg_idx_t'(i);
            tick();
         end
      end
      bus.issue_valid = 0;
      chk("s5_busy_full", bus.busy, 32'hFF);
`else
      bus.issue_valid = 1; bus.issue_rd = 2; bus.chk_rs1 = 2;
      #1;
      chk("nosb_issue_ready", bus.issue_ready, 1);
      tick();
      chk("nosb_busy", bus.busy, 0);
      chk("nosb_hazard", bus.hazard_rs1, 0);
      chk("nosb_issue_ready2", bus.issue_ready, 1);
      bus.issue_valid = 0;
`endif

      // Asynchronous reset while a write is in flight
      bus.alu_valid = 1; bus.alu_rd = 0; bus.alu_data = 19'h0ABCD;
      arb_step();
      bus.alu_valid = 0;
      chk("s5_we_inflight", bus.rf_we, 1);
      #1;
      rst_n = 1'b0;
      q.delete();
      m_last_mem = 1'b1;
      #1;
      chk("s5_async_we", bus.rf_we, 0);
      chk("s5_async_busy", bus.busy, 0);
      @(negedge clk);
      rst_n = 1'b1;
      bus.alu_valid = 1; bus.alu_rd = 6; bus.alu_data = 19'h66666;
      bus.mem_valid = 1; bus.mem_rd = 7; bus.mem_data = 19'h77777;
      arb_step();
      arb_step();
      bus.alu_valid = 0; bus.mem_valid = 0;
      chk("s5_post_rd", bus.rf_rd, 7);
      tick();
      tick();
      chk("queue_empty", q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
